// File: rtl/shift_unit_pkg.sv
// Shared processor package: shift-op encodings, request payload and bit-reverse helper.
package shift_unit_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_RSV = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    shift_op_e          op;
  } shift_req_t;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      r[i] = x[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_unit_sll.sv
// 32-bit logarithmic left barrel shifter, zero fill.
module sll
  import shift_unit_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  y
);

  logic [DATA_W-1:0] stage [SHAMT_W+1];

  assign stage[0] = a;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int unsigned SH = 1 << i;
    assign stage[i+1] = shamt[i] ? {stage[i][DATA_W-SH-1:0], {SH{1'b0}}} : stage[i];
  end

  assign y = stage[SHAMT_W];

endmodule

// File: rtl/shift_unit.sv
// Two-stage sll/srl/sra shift pipeline with valid/ready handshake and flush.
// Define SHIFT_SRA_EN to enable arithmetic right shift; otherwise op 10 is reported illegal.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [SHAMT_W-1:0]  in_shamt,
  input  logic [1:0]          in_op,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_illegal
);

  logic              s1_valid;
  shift_req_t        s1_req;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_advance;
  logic              accept;

  logic [DATA_W-1:0] sh_in;
  logic [DATA_W-1:0] sh_out;
  logic [DATA_W-1:0] srl_res;
  logic [DATA_W-1:0] result;
  logic              illegal;

  // Handshake: S2 is the output register, so out_valid doubles as s2_valid.
  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;

  // Right shifts reuse the left shifter on bit-reversed data.
  assign sh_in   = (s1_req.op == SH_SLL) ? s1_req.data : bit_rev(s1_req.data);
  assign srl_res = bit_rev(sh_out);

  sll u_sll_data (
    .a     (sh_in),
    .shamt (s1_req.shamt),
    .y     (sh_out)
  );

`ifdef SHIFT_SRA_EN
  logic [DATA_W-1:0] fill_lo;
  logic [DATA_W-1:0] fill;

  // Top shamt bits set to the sign bit; zero when shamt is 0.
  sll u_sll_fill (
    .a     ({DATA_W{1'b1}}),
    .shamt (s1_req.shamt),
    .y     (fill_lo)
  );

  assign fill = ~bit_rev(fill_lo) & {DATA_W{s1_req.data[DATA_W-1]}};
`endif

  always_comb begin
    result  = s1_req.data;
    illegal = 1'b1;
    case (s1_req.op)
      SH_SLL: begin
        result  = sh_out;
        illegal = 1'b0;
      end
      SH_SRL: begin
        result  = srl_res;
        illegal = 1'b0;
      end
`ifdef SHIFT_SRA_EN
      SH_SRA: begin
        result  = srl_res | fill;
        illegal = 1'b0;
      end
`endif
      default: begin
        result  = s1_req.data;
        illegal = 1'b1;
      end
    endcase
  end

  // S1: request register; flush wins over acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_req.data  <= in_data;
        s1_req.shamt <= in_shamt;
        s1_req.op    <= shift_op_e'(in_op);
        s1_tag       <= in_tag;
      end
    end
  end

  // S2: result register; payload only loads with a valid entry so it reads 0 until the first result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= result;
        out_tag     <= s1_tag;
        out_illegal <= illegal;
      end
    end
  end

endmodule
